// File: rtl/seq_detect_param_if.sv
// Serial detector bus: qualified input stream plus match status outputs.
// With SEQDET_MASK_EN defined the bus also carries the LEN-bit pat_mask.
interface seq_detect_param_if #(
`ifdef SEQDET_MASK_EN
    parameter int unsigned LEN = 3,
`endif
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             x;
    logic             y;
    logic             armed;
    logic [CNT_W-1:0] match_cnt;
`ifdef SEQDET_MASK_EN
    logic [LEN-1:0]   pat_mask;

    modport master (output en, clr, x, pat_mask, input y, armed, match_cnt);
    modport slave  (input en, clr, x, pat_mask, output y, armed, match_cnt);
`else
    modport master (output en, clr, x, input y, armed, match_cnt);
    modport slave  (input en, clr, x, output y, armed, match_cnt);
`endif
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial pattern detector with qualifier, sync clear and
// saturating match counter. Optional per-bit don't-care mask: SEQDET_MASK_EN.
module seq_detect_param #(
    parameter int unsigned    LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter bit             OVERLAP = 1'b1,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    seq_detect_param_if.slave bus
);
    localparam logic [5:0]       FILL_FULL = 6'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if (LEN < 2 || LEN > 32) begin : g_bad_len
        $error("seq_detect_param: LEN must be 2..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W must be 1..32");
    end

    logic [LEN-1:0]   hist_q, hist_d;
    logic [5:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN-1:0]   care;
    logic             armed_cur;
    logic             match_cur;
    logic             match_next;

`ifdef SEQDET_MASK_EN
    assign care = bus.pat_mask;
`else
    assign care = '1;
`endif

    // Fill gating keeps the all-zero post-reset history from aliasing PATTERN=0.
    assign armed_cur = (fill_q == FILL_FULL);
    assign match_cur = armed_cur && (((hist_q ^ PATTERN) & care) == '0);

    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        match_next = 1'b0;
        if (bus.clr) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (bus.en) begin
            hist_d = {hist_q[LEN-2:0], bus.x};
            if (!OVERLAP && match_cur) begin
                fill_d = 6'd1;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 6'd1;
            end
            match_next = (fill_d == FILL_FULL) && (((hist_d ^ PATTERN) & care) == '0);
            if (match_next && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.y         = match_cur;
    assign bus.armed     = armed_cur;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: four detector configurations against a queue-based window model.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic x = 1'b0, en = 1'b0, clr = 1'b0;
    logic [31:0] mask_drv [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef SEQDET_MASK_EN
    seq_detect_param_if #(.LEN(3), .CNT_W(8)) if_def ();
    seq_detect_param_if #(.LEN(3), .CNT_W(8)) if_nov ();
    seq_detect_param_if #(.LEN(4), .CNT_W(8)) if_zer ();
    seq_detect_param_if #(.LEN(3), .CNT_W(2)) if_sat ();
    assign if_def.pat_mask = mask_drv[0][2:0];
    assign if_nov.pat_mask = mask_drv[1][2:0];
    assign if_zer.pat_mask = mask_drv[2][3:0];
    assign if_sat.pat_mask = mask_drv[3][2:0];
`else
    seq_detect_param_if #(.CNT_W(8)) if_def ();
    seq_detect_param_if #(.CNT_W(8)) if_nov ();
    seq_detect_param_if #(.CNT_W(8)) if_zer ();
    seq_detect_param_if #(.CNT_W(2)) if_sat ();
`endif

    assign if_def.x = x; assign if_def.en = en; assign if_def.clr = clr;
    assign if_nov.x = x; assign if_nov.en = en; assign if_nov.clr = clr;
    assign if_zer.x = x; assign if_zer.en = en; assign if_zer.clr = clr;
    assign if_sat.x = x; assign if_sat.en = en; assign if_sat.clr = clr;

    seq_detect_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8))
        dut_def (.clk(clk), .rst(rst), .bus(if_def));
    seq_detect_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8))
        dut_nov (.clk(clk), .rst(rst), .bus(if_nov));
    seq_detect_param #(.LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8))
        dut_zer (.clk(clk), .rst(rst), .bus(if_zer));
    seq_detect_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2))
        dut_sat (.clk(clk), .rst(rst), .bus(if_sat));

    logic        obs_y [4];
    logic        obs_armed [4];
    logic [31:0] obs_cnt [4];
    always_comb begin
        obs_y[0] = if_def.y; obs_armed[0] = if_def.armed; obs_cnt[0] = 32'(if_def.match_cnt);
        obs_y[1] = if_nov.y; obs_armed[1] = if_nov.armed; obs_cnt[1] = 32'(if_nov.match_cnt);
        obs_y[2] = if_zer.y; obs_armed[2] = if_zer.armed; obs_cnt[2] = 32'(if_zer.match_cnt);
        obs_y[3] = if_sat.y; obs_armed[3] = if_sat.armed; obs_cnt[3] = 32'(if_sat.match_cnt);
    end

    // Reference model: window = bits received since the last restart, oldest first.
    int unsigned m_len [4] = '{3, 3, 4, 3};
    logic [31:0] m_pat [4] = '{32'd5, 32'd5, 32'd0, 32'd5};
    bit          m_ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int unsigned m_max [4] = '{255, 255, 255, 3};
    bit          win [4][$];
    int unsigned m_cnt [4];
    bit          m_y [4];

    function automatic bit window_matches(int k);
        logic [31:0] pat;
        logic [31:0] msk;
        if (win[k].size() != m_len[k]) return 1'b0;
        pat = m_pat[k];
        msk = mask_drv[k];
        for (int i = 0; i < int'(m_len[k]); i++) begin
            if (msk[m_len[k]-1-i] && (win[k][i] != pat[m_len[k]-1-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_armed(int k);
        return win[k].size() == m_len[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            win[k].delete();
            m_cnt[k] = 0;
            m_y[k]   = 1'b0;
        end
    endtask

    task automatic model_step(bit bx, bit ben, bit bclr);
        for (int k = 0; k < 4; k++) begin
            if (bclr) begin
                win[k].delete();
                m_cnt[k] = 0;
                m_y[k]   = 1'b0;
            end else if (ben) begin
                if (!m_ov[k] && m_y[k]) win[k].delete();
                win[k].push_back(bx);
                if (win[k].size() > m_len[k]) void'(win[k].pop_front());
                m_y[k] = window_matches(k);
                if (m_y[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
            end
        end
    endtask

    task automatic drive(bit bx, bit ben, bit bclr);
        @(negedge clk);
        x = bx; en = ben; clr = bclr;
        @(posedge clk);
        model_step(bx, ben, bclr);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; clr = 1'b0; rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        en = 1'b0; clr = 1'b0; rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_y[k] !== 1'b0 || obs_armed[k] !== 1'b0 || obs_cnt[k] !== 32'd0) begin
                n_errors++;
                $display("FAIL reset dut%0d: y=%b armed=%b cnt=%0d, required 0/0/0",
                         k, obs_y[k], obs_armed[k], obs_cnt[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_overlap();
        bit stim [5]  = '{1, 0, 1, 0, 1};
        bit exp_o [5] = '{0, 0, 1, 0, 1};
        bit exp_n [5] = '{0, 0, 1, 0, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(stim[i], 1'b1, 1'b0);
            n_checks++;
            if (obs_y[0] !== exp_o[i]) begin
                n_errors++;
                $display("FAIL overlap_y bit%0d: got %b required %b", i, obs_y[0], exp_o[i]);
            end
            n_checks++;
            if (obs_y[1] !== exp_n[i]) begin
                n_errors++;
                $display("FAIL nonoverlap_y bit%0d: got %b required %b", i, obs_y[1], exp_n[i]);
            end
        end
        n_checks++;
        if (obs_cnt[0] !== 32'd2) begin
            n_errors++;
            $display("FAIL overlap_cnt: got %0d required 2", obs_cnt[0]);
        end
        n_checks++;
        if (obs_cnt[1] !== 32'd1) begin
            n_errors++;
            $display("FAIL nonoverlap_cnt: got %0d required 1", obs_cnt[1]);
        end
    endtask

    task automatic test_en_hold();
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(bit'(i % 2), 1'b0, 1'b0);
            n_checks++;
            if (obs_y[0] !== 1'b0 || obs_armed[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL en_hold_idle cyc%0d: y=%b armed=%b, required 0/0", i, obs_y[0], obs_armed[0]);
            end
        end
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs_y[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL en_hold_third_bit: got %b required 1", obs_y[0]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(bit'(i % 2 == 0), 1'b0, 1'b0);
            n_checks++;
            if (obs_y[0] !== 1'b1 || obs_cnt[0] !== 32'd1) begin
                n_errors++;
                $display("FAIL en_hold_match cyc%0d: y=%b cnt=%0d, required 1/1", i, obs_y[0], obs_cnt[0]);
            end
        end
    endtask

    task automatic test_zero_pattern();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (obs_y[2] !== (i >= 3) || obs_armed[2] !== (i >= 3)) begin
                n_errors++;
                $display("FAIL zero_pattern bit%0d: y=%b armed=%b, required %b/%b",
                         i, obs_y[2], obs_armed[2], i >= 3, i >= 3);
            end
        end
    endtask

    task automatic test_saturate_clr();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(bit'((i % 3) != 1), 1'b1, 1'b0);
            n_checks++;
            if (obs_cnt[3] !== 32'(m_cnt[3])) begin
                n_errors++;
                $display("FAIL sat_cnt bit%0d: got %0d required %0d", i, obs_cnt[3], m_cnt[3]);
            end
        end
        n_checks++;
        if (obs_cnt[3] !== 32'd3) begin
            n_errors++;
            $display("FAIL sat_final: got %0d required 3", obs_cnt[3]);
        end
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_y[k] !== 1'b0 || obs_armed[k] !== 1'b0 || obs_cnt[k] !== 32'd0) begin
                n_errors++;
                $display("FAIL clr dut%0d: y=%b armed=%b cnt=%0d, required 0/0/0",
                         k, obs_y[k], obs_armed[k], obs_cnt[k]);
            end
        end
    endtask

`ifdef SEQDET_MASK_EN
    task automatic test_mask();
        do_reset();
        mask_drv[0] = 32'b101;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs_y[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL mask_dont_care: got %b required 1", obs_y[0]);
        end
        do_reset();
        mask_drv[0] = 32'b111;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs_y[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL mask_exact: got %b required 0", obs_y[0]);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) == 0) begin
                @(negedge clk);
                en = 1'b0; clr = 1'b0; rst = 1'b1;
                model_reset();
                #1;
                n_checks++;
                if (obs_y[0] !== 1'b0 || obs_armed[0] !== 1'b0 || obs_cnt[0] !== 32'd0) begin
                    n_errors++;
                    $display("FAIL mid_reset n%0d: y=%b armed=%b cnt=%0d", n, obs_y[0], obs_armed[0], obs_cnt[0]);
                end
                @(negedge clk);
                rst = 1'b0;
            end
            drive(bit'($urandom_range(1)), $urandom_range(3) != 0, $urandom_range(39) == 0);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (obs_y[k] !== m_y[k] || obs_armed[k] !== m_armed(k) || obs_cnt[k] !== 32'(m_cnt[k])) begin
                    n_errors++;
                    $display("FAIL random n%0d dut%0d: y=%b armed=%b cnt=%0d, required %b/%b/%0d",
                             n, k, obs_y[k], obs_armed[k], obs_cnt[k], m_y[k], m_armed(k), m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) mask_drv[k] = '1;
        model_reset();
        test_reset();
        test_overlap();
        test_en_hold();
        test_zero_pattern();
        test_saturate_clr();
`ifdef SEQDET_MASK_EN
        test_mask();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; next generation of the team's fixed 3-bit Moore "101" detector.
- Pattern value, pattern length and overlap mode are set by parameter; adds input qualification, synchronous clear and a saturating match counter.
- Sits on a 1-bit serial stream; y is a Moore output, a pure function of registered state.

Parameters:
- LEN, 3, pattern length in bits; legal range 2..32.
- PATTERN, 3'b101, LEN-bit target. MSB is the oldest bit received, LSB the newest.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- CNT_W, 8, match counter width; legal range 1..32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  bit-valid qualifier; x is sampled only when en=1.
- clr  in  1  synchronous clear of history, fill and counter.
- x  in  1  serial data bit.
- y  out  1  match flag (Moore).
- armed  out  1  high when fill==LEN, i.e. the history holds a full window.
- match_cnt  out  CNT_W  number of matches, saturating.

Behaviour:
- State registers:
  - hist[LEN-1:0]: shift register; newest bit enters at the LSB.
  - fill[5:0]: count of valid bits in hist, saturating at LEN.
  - match_cnt.
- Reset (rst=1, asynchronous): hist=0, fill=0, match_cnt=0. Resulting outputs: y=0, armed=0, match_cnt=0.
- Priority at each clock edge: rst > clr > en.
  - clr=1: same values as reset, applied synchronously. x and en are ignored that cycle.
  - en=0 (and clr=0): all state holds, so y, armed and match_cnt hold.
  - en=1 (and clr=0):
    - hist <= {hist[LEN-2:0], x}.
    - fill: if OVERLAP==0 and y==1, fill <= 1. Otherwise fill <= min(fill+1, LEN).
- Outputs:
  - armed = (fill==LEN).
  - y = armed && ((hist ^ PATTERN) & care)==0, where care is all ones unless the optional feature is enabled. y is combinational from registered state only; x never reaches y directly.
- Latency: y rises in the cycle after the edge that samples the final pattern bit. It stays high until the next en=1 edge or clr.
- Counter:
  - Increments on any edge where clr=0, en=1 and the next-state match evaluates true.
  - Stays at 2^CNT_W-1 once it reaches that value (no wrap).
  - A match that is held across en=0 cycles counts only once.
- Non-overlap (OVERLAP=0): the bit that follows a match starts a fresh window, with fill=1 containing only that bit. The prefix bits of the completed match are never reused.
- Start-up: no match is possible before LEN qualified bits, because the zero history after reset must not alias a PATTERN of all zeros.
- rst asserted mid-stream: everything is discarded. After release, LEN new qualified bits are required before y can assert.

Optional Feature:
- Macro: SEQDET_MASK_EN.
- Defined: adds input port pat_mask (in, LEN bits), used as care. Bit=1 means the bit is compared; bit=0 means don't-care. pat_mask=0 with armed=1 gives y=1 on every qualified bit.
- Not defined: no pat_mask port; care is all ones and the compare is exact.

Test Plan:
- Defaults, en=1, x stream 1,0,1,0,1 -> y high after the 3rd and 5th bits; match_cnt=2.
- OVERLAP=0, same stream 1,0,1,0,1 -> y high after the 3rd bit only; match_cnt=1.
- Defaults, stream 1,0, then en=0 for 4 cycles with x toggling, then en=1 and x=1 -> y=1 only after the third qualified bit. y holds its value while en=0.
- LEN=4, PATTERN=4'b0000, rst released, x=0 with en=1 -> y=0 for the first 3 bits and y=1 from the 4th onward. armed rises together with the 4th bit.
- CNT_W=2, stream of eight 101 repetitions (overlap) -> match_cnt saturates at 3. Then clr=1 for one cycle -> match_cnt=0, y=0, armed=0.
- SEQDET_MASK_EN defined, pat_mask=3'b101, stream 1,1,1 -> y=1, because the middle bit is don't-care. With pat_mask=3'b111, the same stream gives y=0.
